regfile_wb_arbiter: RTL and testbench

//  Shares the register file's single write port among NUM_REQ write-back sources (ALU, load unit, CSR/mul).

---
 rtl/riscv_pkg.sv | 9 +
 rtl/regfile_wb_arbiter_rr.sv | 33 +++
 rtl/regfile_wb_arbiter.sv | 93 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core constants: data width, register address width and the hardwired-zero register.
package riscv_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned REG_ADDR_W = 5;

   localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Round-robin priority pick: first set request at or after ptr (mod N) wins.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
   parameter int unsigned N  = 3,
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_c_o,
   output logic [IW-1:0] idx_c_o,
   output logic          any_c_o
);

   logic [IW-1:0] cand;
   logic          found;

   always_comb begin
      gnt_c_o = '0;
      idx_c_o = '0;
      cand    = '0;
      found   = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
         cand = IW'((32'(ptr_i) + k) % N);
         if (!found && req_i[cand]) begin
            found         = 1'b1;
            gnt_c_o[cand] = 1'b1;
            idx_c_o       = cand;
         end
      end
      any_c_o = found;
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NUM_REQ write-back sources.
// Round-robin grant, one registered output stage, x0 writes filtered out.
module regfile_wb_arbiter #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned XLEN    = riscv_pkg::XLEN,
   parameter int unsigned AW      = riscv_pkg::REG_ADDR_W
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wb_hold,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ*AW-1:0]   req_rd,
   input  logic [NUM_REQ*XLEN-1:0] req_data,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic                    reg_write,
   output logic [AW-1:0]           rd,
   output logic [XLEN-1:0]         write_data,
   output logic [2:0]              grant_id,
   output logic                    busy
);

   import riscv_pkg::*;

   localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [IW-1:0]      ptr_q, ptr_d;
   logic [NUM_REQ-1:0] gnt;
   logic [IW-1:0]      win;
   logic               any;
   logic               accept;
   logic [AW-1:0]      sel_rd;
   logic [XLEN-1:0]    sel_data;

   logic               reg_write_q;
   logic [AW-1:0]      rd_q;
   logic [XLEN-1:0]    write_data_q;
   logic [2:0]         grant_id_q;

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .req_i   (req_valid),
      .ptr_i   (ptr_q),
      .gnt_c_o (gnt),
      .idx_c_o (win),
      .any_c_o (any)
   );

   // Nobody is granted while in reset or while the port is held elsewhere.
   assign accept    = any & reset & ~wb_hold;
   assign req_ready = accept ? gnt : '0;
   assign busy      = |(req_valid & ~req_ready);

   always_comb begin
      sel_rd   = '0;
      sel_data = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sel_rd   = sel_rd   | req_rd[i*AW +: AW];
            sel_data = sel_data | req_data[i*XLEN +: XLEN];
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (accept) begin
         ptr_d = (32'(win) == NUM_REQ - 1) ? '0 : win + IW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr_q        <= '0;
         reg_write_q  <= 1'b0;
         rd_q         <= '0;
         write_data_q <= '0;
         grant_id_q   <= '0;
      end else begin
         ptr_q       <= ptr_d;
         reg_write_q <= accept && (sel_rd != AW'(REG_X0));
         if (accept) begin
            rd_q         <= sel_rd;
            write_data_q <= sel_data;
            grant_id_q   <= 3'(win);
         end
      end
   end

   assign reg_write  = reg_write_q;
   assign rd         = rd_q;
   assign write_data = write_data_q;
   assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a scoreboard of expected output-stage values.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_hold;
   logic [2:0]  req_valid;
   logic [14:0] req_rd;
   logic [95:0] req_data;
   logic [2:0]  req_ready;
   logic        reg_write;
   logic [4:0]  rd;
   logic [31:0] write_data;
   logic [2:0]  grant_id;
   logic        busy;

   always #5 clk = ~clk;

   regfile_wb_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .wb_hold    (wb_hold),
      .req_valid  (req_valid),
      .req_rd     (req_rd),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .reg_write  (reg_write),
      .rd         (rd),
      .write_data (write_data),
      .grant_id   (grant_id),
      .busy       (busy)
   );

   typedef struct {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
      logic [2:0]  gid;
      bit          full;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passes = 0;

   // Reference model state
   int          m_ptr   = 0;
   logic [4:0]  m_rd    = '0;
   logic [31:0] m_data  = '0;
   logic [2:0]  m_gid   = '0;
   bit          m_known = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic set_req(input int i, input logic [4:0] r, input logic [31:0] d);
      req_rd[i*5 +: 5]    = r;
      req_data[i*32 +: 32] = d;
   endtask

   // Check the combinational handshake, predict the next output stage, then check it after the edge.
   task automatic step(input string tag, input logic [2:0] exp_rdy, input logic exp_busy);
      exp_t       e;
      exp_t       got;
      int         w;
      int         idx;
      logic [4:0] rdv;
      #1;
      chk({tag, " req_ready"}, 32'(req_ready), 32'(exp_rdy));
      chk({tag, " busy"}, 32'(busy), 32'(exp_busy));
      w = -1;
      if (reset && !wb_hold) begin
         for (int k = 0; k < 3; k++) begin
            idx = (m_ptr + k) % 3;
            if (w < 0 && req_valid[idx]) w = idx;
         end
      end
      if (!reset) begin
         m_ptr = 0; m_rd = '0; m_data = '0; m_gid = '0; m_known = 1'b1;
         e = '{1'b0, 5'd0, 32'd0, 3'd0, 1'b1};
      end else if (w >= 0) begin
         rdv   = req_rd[w*5 +: 5];
         m_ptr = (w + 1) % 3;
         if (rdv != 5'd0) begin
            m_rd = rdv; m_data = req_data[w*32 +: 32]; m_gid = 3'(w); m_known = 1'b1;
            e = '{1'b1, m_rd, m_data, m_gid, 1'b1};
         end else begin
            m_known = 1'b0;
            e = '{1'b0, 5'd0, 32'd0, 3'd0, 1'b0};
         end
      end else begin
         e = '{1'b0, m_rd, m_data, m_gid, m_known};
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         checks++;
         $error("FAIL %s scoreboard observed=empty expected=entry", tag);
      end else begin
         got = sb.pop_front();
         chk({tag, " reg_write"}, 32'(reg_write), 32'(got.we));
         if (got.full) begin
            chk({tag, " rd"}, 32'(rd), 32'(got.rd));
            chk({tag, " write_data"}, write_data, got.data);
            chk({tag, " grant_id"}, 32'(grant_id), 32'(got.gid));
         end
      end
   endtask

   initial begin
      reset = 1'b0; wb_hold = 1'b0; req_valid = 3'b111;
      req_rd = '0; req_data = '0;
      set_req(0, 5'd1, 32'h0000_00A0);
      set_req(1, 5'd2, 32'h0000_00A1);
      set_req(2, 5'd3, 32'h0000_00A2);

      // Reset held with all requesters valid
      step("rst0", 3'b000, 1'b1);
      step("rst1", 3'b000, 1'b1);
      reset = 1'b1;
      step("rel_g0", 3'b001, 1'b1);

      // Single requester 1
      req_valid = 3'b010;
      set_req(1, 5'd5, 32'hDEAD_BEEF);
      step("r1_grant", 3'b010, 1'b0);
      req_valid = 3'b000;
      step("r1_idle", 3'b000, 1'b0);

      // x0 write from requester 2 is accepted but suppressed
      req_valid = 3'b100;
      set_req(2, 5'd0, 32'h0000_1234);
      step("x0_grant", 3'b100, 1'b0);
      req_valid = 3'b000;
      step("x0_idle", 3'b000, 1'b0);

      // All valid: 0,1,2,0,1,2
      set_req(1, 5'd2, 32'h0000_00A1);
      set_req(2, 5'd3, 32'h0000_00A2);
      req_valid = 3'b111;
      step("rr_0a", 3'b001, 1'b1);
      step("rr_1a", 3'b010, 1'b1);
      step("rr_2a", 3'b100, 1'b1);
      step("rr_0b", 3'b001, 1'b1);
      step("rr_1b", 3'b010, 1'b1);
      step("rr_2b", 3'b100, 1'b1);
      req_valid = 3'b000;
      step("rr_idle", 3'b000, 1'b0);

      // Hold blocks the port for three cycles
      wb_hold = 1'b1;
      req_valid = 3'b001;
      step("hold0", 3'b000, 1'b1);
      step("hold1", 3'b000, 1'b1);
      step("hold2", 3'b000, 1'b1);
      wb_hold = 1'b0;
      step("unhold", 3'b001, 1'b0);

      // Grant then reset: output stage discarded
      set_req(0, 5'd7, 32'h0000_0011);
      step("pre_rst", 3'b001, 1'b0);
      req_valid = 3'b000;
      reset = 1'b0;
      step("mid_rst", 3'b000, 1'b0);
      reset = 1'b1;
      set_req(0, 5'd1, 32'h0000_00A0);
      req_valid = 3'b111;
      step("post_rst", 3'b001, 1'b1);
      req_valid = 3'b000;
      step("final", 3'b000, 1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
